// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared FSM state type and output-width helper for the streaming convolution engine
package conv_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_COMP = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  function automatic int yw(input int xw, input int fw, input int m);
    return xw + fw + $clog2(m);
  endfunction

endpackage

// File: rtl/conv_mac_pipe.sv
// rtl/conv_mac_pipe.sv - registered signed product feeding a clearable accumulator, optional ReLU on the result
module conv_mac_pipe #(
  parameter int XW   = 8,
  parameter int FW   = 8,
  parameter int YW   = 18,
  parameter int RELU = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [XW-1:0] x_i,
  input  logic signed [FW-1:0] f_i,
  output logic signed [YW-1:0] y_o
);

  localparam int PW = XW + FW;

  logic signed [PW-1:0] prod_d, prod_q;
  logic signed [YW-1:0] acc_d, acc_q;
  logic                 pv_q;

  always_comb begin
    prod_d = PW'(x_i) * PW'(f_i);
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (pv_q) begin
      acc_d = acc_q + YW'(prod_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      pv_q   <= clr_i ? 1'b0 : en_i;
      acc_q  <= acc_d;
    end
  end

  assign y_o = ((RELU != 0) && acc_q[YW-1]) ? '0 : acc_q;

endmodule

// File: rtl/conv_spram.sv
// rtl/conv_spram.sv - single-port buffer memory, synchronous write, registered read (1-cycle latency)
module conv_spram #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_stream_nm.sv
// rtl/conv_stream_nm.sv - streaming N-sample by M-tap 1-D convolution with valid/ready channels and tap reuse
module conv_stream_nm
  import conv_pkg::*;
#(
  parameter  int XW   = 8,
  parameter  int FW   = 8,
  parameter  int N    = 8,
  parameter  int M    = 4,
  parameter  int RELU = 0,
  localparam int YW   = yw(XW, FW, M)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [XW-1:0] s_data_x,
  input  logic                 s_valid_x,
  output logic                 s_ready_x,
  input  logic signed [FW-1:0] s_data_f,
  input  logic                 s_valid_f,
  output logic                 s_ready_f,
  input  logic                 keep_f,
  output logic signed [YW-1:0] m_data_y,
  output logic                 m_valid_y,
  input  logic                 m_ready_y
);

  localparam int CW  = $clog2(N + 1);
  localparam int XAW = $clog2(N);
  localparam int FAW = $clog2(M);
  localparam int KW  = $clog2(M + 3);

  localparam logic [CW-1:0] X_FULL  = CW'(N);
  localparam logic [CW-1:0] F_FULL  = CW'(M);
  localparam logic [CW-1:0] J_LAST  = CW'(N - M);
  localparam logic [KW-1:0] K_ISSUE = KW'(M);
  localparam logic [KW-1:0] K_DONE  = KW'(M + 2);

  state_e state_q, state_d;

  logic [CW-1:0] x_cnt_q, x_cnt_d;
  logic [CW-1:0] f_cnt_q, f_cnt_d;
  logic [CW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic          rv_q;
  logic          rdy_x_q, rdy_x_d;
  logic          rdy_f_q, rdy_f_d;
  logic          m_valid_q, m_valid_d;
  logic signed [YW-1:0] m_data_q, m_data_d;

  logic x_fire, f_fire, y_fire, issue, entering;
  logic [XAW-1:0] x_addr;
  logic [FAW-1:0] f_addr;
  logic signed [XW-1:0] x_rd;
  logic signed [FW-1:0] f_rd;
  logic signed [YW-1:0] mac_y;

  assign x_fire   = s_valid_x && rdy_x_q;
  assign f_fire   = s_valid_f && rdy_f_q;
  assign y_fire   = m_valid_q && m_ready_y;
  assign issue    = (state_q == S_COMP) && (k_q < K_ISSUE);
  assign entering = (state_d == S_COMP) && (state_q != S_COMP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD: if (x_cnt_q == X_FULL && f_cnt_q == F_FULL) state_d = S_COMP;
      S_COMP: if (k_q == K_DONE) state_d = S_OUT;
      S_OUT:  if (m_ready_y) state_d = (j_q < J_LAST) ? S_COMP : S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // k_q paces one read per cycle, then waits out the memory/product/accumulate stages.
  always_comb begin
    x_cnt_d   = x_cnt_q;
    f_cnt_d   = f_cnt_q;
    j_d       = j_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    if (x_fire) x_cnt_d = x_cnt_q + CW'(1);
    if (f_fire) f_cnt_d = f_cnt_q + CW'(1);

    if (entering) begin
      k_d = '0;
    end else if (state_q == S_COMP && k_q != K_DONE) begin
      k_d = k_q + KW'(1);
    end

    if (state_q == S_COMP && k_q == K_DONE) begin
      m_valid_d = 1'b1;
      m_data_d  = mac_y;
    end

    if (y_fire) begin
      m_valid_d = 1'b0;
      if (j_q < J_LAST) begin
        j_d = j_q + CW'(1);
      end else begin
        j_d     = '0;
        x_cnt_d = '0;
        if (!keep_f) f_cnt_d = '0;
      end
    end

    rdy_x_d = (state_d == S_LOAD) && (x_cnt_d < X_FULL);
    rdy_f_d = (state_d == S_LOAD) && (f_cnt_d < F_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt_q   <= '0;
      f_cnt_q   <= '0;
      j_q       <= '0;
      k_q       <= '0;
      rv_q      <= 1'b0;
      rdy_x_q   <= 1'b0;
      rdy_f_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      x_cnt_q   <= x_cnt_d;
      f_cnt_q   <= f_cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      rv_q      <= issue;
      rdy_x_q   <= rdy_x_d;
      rdy_f_q   <= rdy_f_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // Reads only happen while j+k < N, so the truncating casts cannot alias.
  assign x_addr = (state_q == S_LOAD) ? x_cnt_q[XAW-1:0] : (XAW'(j_q) + XAW'(k_q));
  assign f_addr = (state_q == S_LOAD) ? f_cnt_q[FAW-1:0] : k_q[FAW-1:0];

  conv_spram #(.W(XW), .DEPTH(N)) u_xbuf (
    .clk     (clk),
    .we_i    (x_fire),
    .addr_i  (x_addr),
    .wdata_i (s_data_x),
    .rdata_o (x_rd)
  );

  conv_spram #(.W(FW), .DEPTH(M)) u_fbuf (
    .clk     (clk),
    .we_i    (f_fire),
    .addr_i  (f_addr),
    .wdata_i (s_data_f),
    .rdata_o (f_rd)
  );

  conv_mac_pipe #(.XW(XW), .FW(FW), .YW(YW), .RELU(RELU)) u_mac (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (entering),
    .en_i  (rv_q),
    .x_i   (x_rd),
    .f_i   (f_rd),
    .y_o   (mac_y)
  );

  assign s_ready_x = rdy_x_q;
  assign s_ready_f = rdy_f_q;
  assign m_valid_y = m_valid_q;
  assign m_data_y  = m_data_q;

endmodule

// File: tb/tb_conv_stream_nm.sv
// tb/tb_conv_stream_nm.sv - directed self-checking bench for conv_stream_nm (plain and ReLU instances)
module tb_conv_stream_nm;

  logic clk = 1'b0;
  logic reset;
  logic signed [7:0] s_data_x, s_data_f;
  logic s_valid_x, s_valid_f, keep_f, m_ready_y;
  logic s_ready_x, s_ready_f, m_valid_y;
  logic signed [17:0] m_data_y;
  logic s_ready_x_r, s_ready_f_r, m_valid_y_r;
  logic signed [17:0] m_data_y_r;

  always #5 clk = ~clk;

  conv_stream_nm #(.XW(8), .FW(8), .N(8), .M(4), .RELU(0)) dut (
    .clk(clk), .reset(reset),
    .s_data_x(s_data_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_data_f(s_data_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .keep_f(keep_f),
    .m_data_y(m_data_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y)
  );

  conv_stream_nm #(.XW(8), .FW(8), .N(8), .M(4), .RELU(1)) dut_r (
    .clk(clk), .reset(reset),
    .s_data_x(s_data_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x_r),
    .s_data_f(s_data_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f_r),
    .keep_f(keep_f),
    .m_data_y(m_data_y_r), .m_valid_y(m_valid_y_r), .m_ready_y(m_ready_y)
  );

  int checks = 0;
  int errors = 0;

  logic signed [7:0] cur_x [8];
  logic signed [7:0] cur_f [4];
  int got_y [5];
  int got_yr [5];

  int x1 [8] = '{10, -20, 30, -40, 50, 60, 70, 80};
  int f1 [4] = '{10, 20, -30, 40};
  int x2 [8] = '{-90, 100, -110, 120, -50, 40, 30, -20};
  int xe [8] = '{-128, -128, -128, -128, -128, -128, -128, -128};
  int fe [4] = '{-128, -128, -128, -128};
  int exp1 [5] = '{-2800, 3600, 400, 1600, 2800};
  int exp1r [5] = '{0, 3600, 400, 1600, 2800};
  int exp2 [5] = '{9200, -6800, 4400, 200, -1400};
  int exp2r [5] = '{9200, 0, 4400, 200, 0};

  task automatic set_batch(input int xs [8], input int fs [4]);
    for (int i = 0; i < 8; i++) cur_x[i] = 8'(xs[i]);
    for (int i = 0; i < 4; i++) cur_f[i] = 8'(fs[i]);
  endtask

  task automatic load_batch(input bit send_f, output bit f_ready_seen);
    int xi = 0;
    int fi = 0;
    int cyc = 0;
    f_ready_seen = 1'b0;
    while ((xi < 8 || (send_f && fi < 4)) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (s_ready_f) f_ready_seen = 1'b1;
      s_valid_x = (xi < 8) && ($urandom_range(0, 3) != 0);
      s_data_x  = (xi < 8) ? cur_x[xi] : 8'sd0;
      s_valid_f = send_f && (fi < 4) && ($urandom_range(0, 3) != 0);
      s_data_f  = (fi < 4) ? cur_f[fi] : 8'sd0;
      if (s_valid_x && s_ready_x) xi++;
      if (s_valid_f && s_ready_f) fi++;
    end
    checks++;
    if (xi != 8 || (send_f && fi != 4)) begin
      errors++;
      $display("FAIL load_timeout: sent x=%0d f=%0d, required x=8 f=%0d", xi, fi, send_f ? 4 : 0);
    end
    @(negedge clk);
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
  endtask

  task automatic collect(input int n, input bit rand_ready);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      m_ready_y = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (m_valid_y && m_ready_y) begin
        got_y[k]  = int'(m_data_y);
        got_yr[k] = int'(m_data_y_r);
        k++;
      end
    end
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL collect_timeout: got %0d outputs, required %0d", k, n);
    end
    @(negedge clk);
    m_ready_y = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (m_valid_y !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", m_valid_y); end
    if (m_data_y !== 18'sd0) begin errors++; $display("FAIL reset_m_data: got %0d required 0", m_data_y); end
    if (s_ready_x !== 1'b0) begin errors++; $display("FAIL reset_s_ready_x: got %b required 0", s_ready_x); end
    if (s_ready_f !== 1'b0) begin errors++; $display("FAIL reset_s_ready_f: got %b required 0", s_ready_f); end
    reset = 1'b1;
    @(negedge clk);
    checks += 2;
    if (s_ready_x !== 1'b1) begin errors++; $display("FAIL release_s_ready_x: got %b required 1", s_ready_x); end
    if (s_ready_f !== 1'b1) begin errors++; $display("FAIL release_s_ready_f: got %b required 1", s_ready_f); end
  endtask

  task automatic test_basic();
    bit seen;
    set_batch(x1, f1);
    keep_f = 1'b1;
    load_batch(1'b1, seen);
    collect(5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if (got_y[k] != exp1[k]) begin errors++; $display("FAIL basic_y%0d: got %0d required %0d", k, got_y[k], exp1[k]); end
      if (got_yr[k] != exp1r[k]) begin errors++; $display("FAIL relu_y%0d: got %0d required %0d", k, got_yr[k], exp1r[k]); end
    end
  endtask

  task automatic test_keep_f();
    bit seen;
    set_batch(x2, f1);
    load_batch(1'b0, seen);
    checks++;
    if (seen) begin errors++; $display("FAIL keep_f_ready: s_ready_f got 1 required 0"); end
    keep_f = 1'b0;
    collect(5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if (got_y[k] != exp2[k]) begin errors++; $display("FAIL keep_y%0d: got %0d required %0d", k, got_y[k], exp2[k]); end
      if (got_yr[k] != exp2r[k]) begin errors++; $display("FAIL keep_relu_y%0d: got %0d required %0d", k, got_yr[k], exp2r[k]); end
    end
    checks++;
    if (s_ready_f !== 1'b1) begin errors++; $display("FAIL release_taps: s_ready_f got %b required 1", s_ready_f); end
  endtask

  task automatic test_extremes();
    bit seen;
    set_batch(xe, fe);
    keep_f = 1'b0;
    load_batch(1'b1, seen);
    collect(5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if (got_y[k] != 65536) begin errors++; $display("FAIL extreme_y%0d: got %0d required 65536", k, got_y[k]); end
      if (got_yr[k] != 65536) begin errors++; $display("FAIL extreme_relu_y%0d: got %0d required 65536", k, got_yr[k]); end
    end
  endtask

  task automatic test_back_to_back_stall();
    bit seen;
    bit stable;
    bit blocked;
    int gap;
    logic signed [17:0] held;
    set_batch(x1, f1);
    keep_f = 1'b0;
    load_batch(1'b1, seen);
    m_ready_y = 1'b0;
    for (int k = 0; k < 5; k++) begin
      gap = 0;
      @(negedge clk);
      m_ready_y = 1'b0;
      while (!m_valid_y && gap < 100) begin
        gap++;
        @(negedge clk);
      end
      checks++;
      if (!m_valid_y) begin errors++; $display("FAIL stall_wait_y%0d: m_valid_y got 0 required 1", k); end
      if (k > 0) begin
        checks++;
        if (gap != 7) begin errors++; $display("FAIL latency_y%0d: got %0d cycles required 7", k, gap); end
      end
      if (k == 2) begin
        held = m_data_y;
        stable = 1'b1;
        blocked = 1'b1;
        s_valid_x = 1'b1; s_data_x = 8'sd99;
        s_valid_f = 1'b1; s_data_f = 8'sd99;
        repeat (20) begin
          @(negedge clk);
          if (m_valid_y !== 1'b1 || m_data_y !== held) stable = 1'b0;
          if (s_ready_x !== 1'b0 || s_ready_f !== 1'b0) blocked = 1'b0;
        end
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
        checks += 2;
        if (!stable) begin errors++; $display("FAIL stall_hold: valid=%b data=%0d required 1 and %0d", m_valid_y, m_data_y, held); end
        if (!blocked) begin errors++; $display("FAIL stall_ready: s_ready_x/f got %b/%b required 0/0", s_ready_x, s_ready_f); end
      end
      got_y[k] = int'(m_data_y);
      m_ready_y = 1'b1;
    end
    @(negedge clk);
    m_ready_y = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got_y[k] != exp1[k]) begin errors++; $display("FAIL stall_y%0d: got %0d required %0d", k, got_y[k], exp1[k]); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit stray;
    int cyc;
    set_batch(x1, f1);
    keep_f = 1'b0;
    load_batch(1'b1, seen);
    cyc = 0;
    while (!m_valid_y && cyc < 100) begin @(negedge clk); cyc++; end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (m_valid_y !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", m_valid_y); end
    @(negedge clk);
    reset = 1'b1;

    load_batch(1'b1, seen);
    cyc = 0;
    while (!m_valid_y && cyc < 100) begin @(negedge clk); cyc++; end
    m_ready_y = 1'b1;
    @(negedge clk);
    m_ready_y = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 3;
    if (m_valid_y !== 1'b0) begin errors++; $display("FAIL reset_comp_valid: got %b required 0", m_valid_y); end
    if (m_data_y !== 18'sd0) begin errors++; $display("FAIL reset_comp_data: got %0d required 0", m_data_y); end
    if (s_ready_x !== 1'b0) begin errors++; $display("FAIL reset_comp_ready: got %b required 0", s_ready_x); end
    @(negedge clk);
    reset = 1'b1;

    load_batch(1'b1, seen);
    collect(5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got_y[k] != exp1[k]) begin errors++; $display("FAIL restart_y%0d: got %0d required %0d", k, got_y[k], exp1[k]); end
    end
    stray = 1'b0;
    m_ready_y = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (m_valid_y || m_valid_y_r) stray = 1'b1;
    end
    m_ready_y = 1'b0;
    checks++;
    if (stray) begin errors++; $display("FAIL stray_valid: m_valid_y got 1 required 0"); end
  endtask

  initial begin
    reset = 1'b0;
    s_data_x = '0; s_valid_x = 1'b0;
    s_data_f = '0; s_valid_f = 1'b0;
    keep_f = 1'b0; m_ready_y = 1'b0;
    test_reset();
    test_basic();
    test_keep_f();
    test_extremes();
    test_back_to_back_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
